// File: rtl/ltf_sync_fsm_pkg.sv
// Shared definitions for the LTF sync detector: FSM encoding, ratio scaling
// and the default noise floor.
package ltf_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLATEAU = 2'd1,
        ST_TRACK   = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    // cfg_ratio is a fraction over 2**RATIO_SHIFT
    localparam int RATIO_SHIFT   = 4;
    localparam int LTF_DEF_NOISE = 15000;

endpackage

// File: rtl/ltf_sync_fsm_if.sv
// Sample input stream and detection-record output stream of the LTF detector.
// The slave view is the detector itself; the master view is its environment.
interface ltf_sync_fsm_if #(
    parameter int MAG_WIDTH = 26,
    parameter int IDX_WIDTH = 32
);
    logic                 i_tvalid;
    logic                 i_tready;
    logic                 i_tlast;
    logic [MAG_WIDTH-1:0] corr_mag;
    logic [MAG_WIDTH-1:0] pow_mag;

    logic                 det_tvalid;
    logic                 det_tready;
    logic                 det_tlast;
    logic [IDX_WIDTH-1:0] det_idx;
    logic [MAG_WIDTH-1:0] det_mag;
    logic [MAG_WIDTH-1:0] det_pow;

    modport slave (
        input  i_tvalid, i_tlast, corr_mag, pow_mag, det_tready,
        output i_tready, det_tvalid, det_tlast, det_idx, det_mag, det_pow
    );

    modport master (
        output i_tvalid, i_tlast, corr_mag, pow_mag, det_tready,
        input  i_tready, det_tvalid, det_tlast, det_idx, det_mag, det_pow
    );
endinterface

// File: rtl/ltf_sync_fsm_ratio_cmp.sv
// Registered threshold compare: corr/pow ratio test plus noise gate on both
// magnitudes, loaded only on accepted samples.
module ltf_ratio_cmp
    import ltf_sync_pkg::*;
#(
    parameter int MAG_WIDTH = 26
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 en,
    input  logic [MAG_WIDTH-1:0] corr_mag,
    input  logic [MAG_WIDTH-1:0] pow_mag,
    input  logic [3:0]           ratio,
    input  logic [MAG_WIDTH-1:0] thr,
    output logic                 above
);
    localparam int PROD_W = MAG_WIDTH + RATIO_SHIFT;

    // Full-width products so neither side can wrap.
    function automatic logic ratio_above(
        input logic [MAG_WIDTH-1:0] corr,
        input logic [MAG_WIDTH-1:0] pow,
        input logic [3:0]           num,
        input logic [MAG_WIDTH-1:0] floor_v
    );
        logic [PROD_W-1:0] lhs;
        logic [PROD_W-1:0] rhs;
        lhs = {corr, {RATIO_SHIFT{1'b0}}};
        rhs = PROD_W'(pow) * PROD_W'(num);
        return (lhs > rhs) && (pow > floor_v) && (corr > floor_v);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            above <= 1'b0;
        end else if (clear) begin
            above <= 1'b0;
        end else if (en) begin
            above <= ratio_above(corr_mag, pow_mag, ratio, thr);
        end
    end

endmodule

// File: rtl/ltf_sync_fsm.sv
// LTF/preamble detector back end: plateau qualification, peak search, holdoff
// and a 1-deep detection record register with sticky overflow.
module ltf_sync_fsm
    import ltf_sync_pkg::*;
#(
    parameter int MAG_WIDTH = 26,
    parameter int CNT_WIDTH = 12,
    parameter int IDX_WIDTH = 32,
    parameter int DEF_NOISE = LTF_DEF_NOISE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 cfg_arm,
    input  logic [3:0]           cfg_ratio,
    input  logic [MAG_WIDTH-1:0] cfg_noise_thres,
    input  logic [CNT_WIDTH-1:0] cfg_plateau_len,
    input  logic [CNT_WIDTH-1:0] cfg_search_len,
    input  logic [CNT_WIDTH-1:0] cfg_holdoff_len,
    ltf_sync_fsm_if.slave        bus,
    output logic                 det_ovf,
    output logic [1:0]           state,
    output logic                 above
);

    logic                 w_accept;
    logic [MAG_WIDTH-1:0] w_thr;
    logic [CNT_WIDTH-1:0] w_plen;
    logic [CNT_WIDTH-1:0] w_slen;

    logic [IDX_WIDTH-1:0] r_idx;

    logic                 r_vld_p1;
    logic [MAG_WIDTH-1:0] r_corr_p1;
    logic [MAG_WIDTH-1:0] r_pow_p1;
    logic [IDX_WIDTH-1:0] r_idx_p1;
    logic                 r_tlast_p1;

    state_t               r_state;
    state_t               w_state_n;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_n;
    logic [CNT_WIDTH-1:0] w_cnt_inc;
    logic                 w_seed;
    logic                 w_upd;
    logic                 w_emit;

    logic [MAG_WIDTH-1:0] r_max;
    logic [IDX_WIDTH-1:0] r_max_idx;
    logic [MAG_WIDTH-1:0] r_max_pow;
    logic                 r_max_tlast;
    logic                 w_take;
    logic                 w_build_ld;
    logic [MAG_WIDTH-1:0] w_rec_mag;
    logic [IDX_WIDTH-1:0] w_rec_idx;
    logic [MAG_WIDTH-1:0] w_rec_pow;
    logic                 w_rec_tlast;

    logic                 r_det_vld;
    logic                 r_det_tlast;
    logic [IDX_WIDTH-1:0] r_det_idx;
    logic [MAG_WIDTH-1:0] r_det_mag;
    logic [MAG_WIDTH-1:0] r_det_pow;
    logic                 r_ovf;

    // The block never back-pressures; clear blocks acceptance for its cycle.
    assign bus.i_tready = reset_n & ~clear;
    assign w_accept     = bus.i_tvalid & ~clear;

    assign w_thr  = (cfg_noise_thres == '0) ? MAG_WIDTH'(DEF_NOISE) : cfg_noise_thres;
    assign w_plen = (cfg_plateau_len == '0) ? CNT_WIDTH'(1) : cfg_plateau_len;
    assign w_slen = (cfg_search_len  == '0) ? CNT_WIDTH'(1) : cfg_search_len;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx <= '0;
        end else if (clear) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= r_idx + IDX_WIDTH'(1);
        end
    end

    // ---- stage p1: accepted sample aligned with its registered compare ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_p1 <= 1'b0;
        end else if (clear) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_accept;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_corr_p1  <= bus.corr_mag;
            r_pow_p1   <= bus.pow_mag;
            r_idx_p1   <= r_idx;
            r_tlast_p1 <= bus.i_tlast;
        end
    end

    ltf_ratio_cmp #(
        .MAG_WIDTH (MAG_WIDTH)
    ) u_cmp (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .en       (w_accept),
        .corr_mag (bus.corr_mag),
        .pow_mag  (bus.pow_mag),
        .ratio    (cfg_ratio),
        .thr      (w_thr),
        .above    (above)
    );

    // ---- FSM: one step per stage-p1 sample; disarm acts on any clock ----
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_cnt_inc = r_cnt + CNT_WIDTH'(1);
        w_seed    = 1'b0;
        w_upd     = 1'b0;
        w_emit    = 1'b0;
        if (!cfg_arm) begin
            w_state_n = ST_IDLE;
            w_cnt_n   = '0;
        end else if (r_vld_p1) begin
            case (r_state)
                ST_IDLE: begin
                    w_state_n = ST_PLATEAU;
                    w_cnt_n   = '0;
                end
                ST_PLATEAU: begin
                    w_cnt_n = above ? w_cnt_inc : '0;
                    if (above && (w_cnt_inc >= w_plen)) begin
                        w_seed    = 1'b1;
                        w_state_n = ST_TRACK;
                        w_cnt_n   = CNT_WIDTH'(1);
                        w_emit    = (w_slen == CNT_WIDTH'(1));
                    end
                end
                ST_TRACK: begin
                    w_cnt_n = w_cnt_inc;
                    w_upd   = (r_corr_p1 > r_max);
                    w_emit  = (w_cnt_inc >= w_slen);
                end
                ST_HOLDOFF: begin
                    w_cnt_n = w_cnt_inc;
                    if (w_cnt_inc >= cfg_holdoff_len) begin
                        w_state_n = ST_PLATEAU;
                        w_cnt_n   = '0;
                    end
                end
                default: begin
                    w_state_n = ST_IDLE;
                end
            endcase
            if (w_emit) begin
                w_state_n = (cfg_holdoff_len == '0) ? ST_PLATEAU : ST_HOLDOFF;
                w_cnt_n   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (clear) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
        end
    end

    // Record under construction; the emitted record uses the post-update view.
    assign w_take      = w_seed | w_upd;
    assign w_build_ld  = w_seed | (cfg_arm & r_vld_p1 & (r_state == ST_TRACK));
    assign w_rec_mag   = w_take ? r_corr_p1 : r_max;
    assign w_rec_idx   = w_take ? r_idx_p1  : r_max_idx;
    assign w_rec_pow   = w_take ? r_pow_p1  : r_max_pow;
    assign w_rec_tlast = w_seed ? r_tlast_p1 : (r_max_tlast | r_tlast_p1);

    always_ff @(posedge clk) begin
        if (w_build_ld) begin
            r_max       <= w_rec_mag;
            r_max_idx   <= w_rec_idx;
            r_max_pow   <= w_rec_pow;
            r_max_tlast <= w_rec_tlast;
        end
    end

    // ---- stage p2: 1-deep output record; drop and flag when still stalled ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_det_vld   <= 1'b0;
            r_det_tlast <= 1'b0;
            r_det_idx   <= '0;
            r_det_mag   <= '0;
            r_det_pow   <= '0;
            r_ovf       <= 1'b0;
        end else if (clear) begin
            r_det_vld   <= 1'b0;
            r_det_tlast <= 1'b0;
            r_det_idx   <= '0;
            r_det_mag   <= '0;
            r_det_pow   <= '0;
            r_ovf       <= 1'b0;
        end else if (w_emit && r_det_vld && !bus.det_tready) begin
            r_ovf <= 1'b1;
        end else if (w_emit) begin
            r_det_vld   <= 1'b1;
            r_det_tlast <= w_rec_tlast;
            r_det_idx   <= w_rec_idx;
            r_det_mag   <= w_rec_mag;
            r_det_pow   <= w_rec_pow;
        end else if (r_det_vld && bus.det_tready) begin
            r_det_vld <= 1'b0;
        end
    end

    assign bus.det_tvalid = r_det_vld;
    assign bus.det_tlast  = r_det_tlast;
    assign bus.det_idx    = r_det_idx;
    assign bus.det_mag    = r_det_mag;
    assign bus.det_pow    = r_det_pow;
    assign det_ovf        = r_ovf;
    assign state          = r_state;

endmodule
